multicycle_control: RTL and testbench

Moore/Mealy control FSM that sequences the shared multicycle datapath: one ALU, one unified instruction/data memory and one register file, reused across several cycles per instruction. Each cycle it drives the datapath muxes, including the ALU first/second-operand selects, the ALU operation class and the write strobes. It stalls on a memory-ready handshake. It sits between the instruction register opcode field and the datapath, replacing the single-cycle combinational control unit.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath (slave).
// mem_ready handshake: the controller holds its memory request (MemRead/MemWrite, IorD) stable
// in FETCH/MEMRD/MEMWR, and the access completes on the rising edge where mem_ready is high.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       IRWrite;
  logic       PCWrite;
  logic       PCEn;
  logic       Branch;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;

  modport master (
    input  opcode, zero, mem_ready,
    output IRWrite, PCWrite, PCEn, Branch, IorD, MemRead, MemWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IRWrite, PCWrite, PCEn, Branch, IorD, MemRead, MemWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle datapath: sequences one instruction over several
// cycles, stalls on mem_ready in the memory states, and exposes its state on state_dbg.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus,
  output logic [3:0]                  state_dbg
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state;
  state_t     state_next;
  logic       is_store;

  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       memtoreg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // MEMADR picks lw vs sw from this flag so opcode is only looked at on the DECODE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store <= 1'b0;
    end else if (state == DECODE) begin
      is_store <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    state_next = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    memtoreg   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Strobes follow mem_ready combinationally but are suppressed while reset is held.
        ir_write  = bus.mem_ready & ~reset;
        pc_write  = bus.mem_ready & ~reset;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = is_store ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        memtoreg   = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        branch     = 1'b1;
        pc_src     = 2'b01;
        state_next = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign bus.IRWrite  = ir_write;
  assign bus.PCWrite  = pc_write;
  assign bus.PCEn     = pc_write | (branch & bus.zero);
  assign bus.Branch   = branch;
  assign bus.IorD     = iord;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemtoReg = memtoreg;
  assign bus.RegDst   = reg_dst;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSrc    = pc_src;
  assign state_dbg    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios followed by random instruction streams,
// each cycle checked against a per-instruction state path and per-state output table.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  logic [3:0] state_dbg;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // {IRWrite,PCWrite,PCEn,Branch,IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  logic [16:0] obs_ctrl;
  assign obs_ctrl = {bus.IRWrite, bus.PCWrite, bus.PCEn, bus.Branch, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                     bus.ALUSrcB, bus.ALUOp, bus.PCSrc};

  // reference: control word required in a given state with the current inputs
  function automatic logic [16:0] exp_ctrl(int st, logic mr, logic z, logic rst);
    logic irw, pcw, br, iord, mrd, mwr, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    irw = 0; pcw = 0; br = 0; iord = 0; mrd = 0; mwr = 0; m2r = 0; rdst = 0; rw = 0; asa = 0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr & ~rst; pcw = mr & ~rst; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {irw, pcw, pcw | (br & z), br, iord, mrd, mwr, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  // scoreboard: compare state and full control word right now
  task automatic check_now(string tag, int st);
    logic [16:0] exp;
    exp = exp_ctrl(st, bus.mem_ready, bus.zero, reset);
    n_checks++;
    assert (state_dbg === 4'(st)) else begin
      n_fails++;
      $error("FAIL %s state_dbg: observed %0d expected %0d", tag, state_dbg, st);
    end
    n_checks++;
    assert (obs_ctrl === exp) else begin
      n_fails++;
      $error("FAIL %s ctrl (state %0d): observed %b expected %b", tag, st, obs_ctrl, exp);
    end
  endtask

  // driver: one clock cycle, entered and left at posedge+1
  task automatic cyc(string tag, int st, logic mr, logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    check_now(tag, st);
    @(posedge clk);
    #1;
  endtask

  // whole instruction: fw FETCH wait cycles, mw wait cycles in MEMRD/MEMWR
  task automatic run_instr(string tag, logic [5:0] op, logic z, int fw, int mw);
    bus.opcode = op;
    for (int i = 0; i < fw; i++) cyc(tag, 0, 1'b0, z);
    cyc(tag, 0, 1'b1, z);
    cyc(tag, 1, 1'($urandom), z);
    bus.opcode = 6'($urandom);
    case (op)
      OP_LW: begin
        cyc(tag, 2, 1'($urandom), z);
        for (int i = 0; i < mw; i++) cyc(tag, 3, 1'b0, z);
        cyc(tag, 3, 1'b1, z);
        cyc(tag, 4, 1'($urandom), z);
      end
      OP_SW: begin
        cyc(tag, 2, 1'($urandom), z);
        for (int i = 0; i < mw; i++) cyc(tag, 5, 1'b0, z);
        cyc(tag, 5, 1'b1, z);
      end
      OP_RTYPE: begin
        cyc(tag, 6, 1'($urandom), z);
        cyc(tag, 7, 1'($urandom), z);
      end
      OP_BEQ:  cyc(tag, 8, 1'($urandom), z);
      OP_ADDI: begin
        cyc(tag, 9, 1'($urandom), z);
        cyc(tag, 10, 1'($urandom), z);
      end
      OP_J:    cyc(tag, 11, 1'($urandom), z);
      default: ;
    endcase
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    reset         = 1'b1;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_now("reset", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // directed
    run_instr("rtype",      OP_RTYPE, 1'b0, 0, 0);
    run_instr("lw_wait2",   OP_LW,    1'b0, 0, 2);
    run_instr("sw",         OP_SW,    1'b1, 0, 0);
    run_instr("beq_z1",     OP_BEQ,   1'b1, 0, 0);
    run_instr("beq_z0",     OP_BEQ,   1'b0, 0, 0);
    run_instr("fetch_wait", OP_ADDI,  1'b0, 3, 0);
    run_instr("jump",       OP_J,     1'b1, 0, 0);
    run_instr("illegal",    6'b111111, 1'b1, 0, 0);
    run_instr("sw_wait",    OP_SW,    1'b0, 1, 3);

    // async reset in the middle of a stalled store
    bus.opcode = OP_SW;
    cyc("rst_mid", 0, 1'b1, 1'b0);
    cyc("rst_mid", 1, 1'b1, 1'b0);
    cyc("rst_mid", 2, 1'b1, 1'b0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_now("rst_memwr_pre", 5);
    #2;
    reset = 1'b1;
    #1;
    check_now("rst_memwr_async", 0);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_now("rst_hold", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr("after_rst", OP_LW, 1'b0, 0, 0);

    // random instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 7);
      op  = (sel < 6) ? legal_ops[sel] : 6'($urandom);
      run_instr("rand", op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
